// File: rtl/pc_ras.sv
// Fetch-stage program counter with branches, absolute jumps and a circular return-address stack.
// Optional macro PC_RAS_EN enables RAS storage; without it CALL acts as JABS and RET as NEXT.
module pc_ras #(
  parameter int PC_W      = 8,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = 4,
  parameter int START_PC  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     ctl,
  input  logic                           z,
  input  logic                           neg,
  input  logic [OFF_W-1:0]               bamt,
  input  logic [PC_W-1:0]                target,
  output logic [PC_W-1:0]                PC,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf,
  output logic                           halted
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] CMD_NEXT = 3'd0;
  localparam logic [2:0] CMD_BRZ  = 3'd1;
  localparam logic [2:0] CMD_BRN  = 3'd2;
  localparam logic [2:0] CMD_JREL = 3'd3;
  localparam logic [2:0] CMD_JABS = 3'd4;
  localparam logic [2:0] CMD_CALL = 3'd5;
  localparam logic [2:0] CMD_RET  = 3'd6;
  localparam logic [2:0] CMD_HALT = 3'd7;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] pc_inc, pc_rel, off_ext;

  // Size cast of a signed operand sign-extends the offset to PC width.
  assign off_ext = PC_W'($signed(bamt));
  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_rel  = pc_q + off_ext;

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d, tos_prev, tos_adv;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push, pop, ras_full;

  // tos points at the next free slot; the newest entry sits just below it.
  assign tos_prev = (tos_q == '0) ? PTR_W'(RAS_DEPTH - 1) : tos_q - PTR_W'(1);
  assign tos_adv  = (tos_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : tos_q + PTR_W'(1);
  assign ras_full = (cnt_q == CNT_W'(RAS_DEPTH));
`endif

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
`ifdef PC_RAS_EN
    push  = 1'b0;
    pop   = 1'b0;
    tos_d = tos_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
`endif
    if (!stall && !halted_q) begin
      case (ctl)
        CMD_NEXT: pc_d = pc_inc;
        CMD_BRZ:  pc_d = z   ? pc_rel : pc_inc;
        CMD_BRN:  pc_d = neg ? pc_rel : pc_inc;
        CMD_JREL: pc_d = pc_rel;
        CMD_JABS: pc_d = target;
        CMD_CALL: begin
          pc_d = target;
`ifdef PC_RAS_EN
          push  = 1'b1;
          tos_d = tos_adv;
          if (ras_full) ovf_d = 1'b1;
          else          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
        CMD_RET: begin
`ifdef PC_RAS_EN
          if (cnt_q != '0) begin
            pop   = 1'b1;
            pc_d  = ras_mem[tos_prev];
            tos_d = tos_prev;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end
`else
          pc_d = pc_inc;
`endif
        end
        CMD_HALT: halted_d = 1'b1;
        default:  pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= PC_W'(START_PC);
      halted_q <= 1'b0;
`ifdef PC_RAS_EN
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
`ifdef PC_RAS_EN
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`endif
    end
  end

`ifdef PC_RAS_EN
  // Storage has no reset; emptiness is tracked solely by cnt_q.
  always_ff @(posedge clk) begin
    if (push && !reset) ras_mem[tos_q] <= pc_inc;
  end

  logic unused_pop;
  assign unused_pop = pop;

  assign ras_count = cnt_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
`else
  assign ras_count = '0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

  assign PC     = pc_q;
  assign halted = halted_q;

endmodule
